// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART <-> ALU frame controller family.
package uart_alu_pkg;

  // Default widths shared with the ALU and UART tops.
  localparam int DEF_WORD_W   = 8;
  localparam int DEF_OPERAND  = 16;
  localparam int DEF_OPCODE_W = 8;
  localparam int DEF_RESULT   = 16;

  // Frame controller states, in frame order.
  typedef enum logic [2:0] {
    ST_RX_A     = 3'd0,
    ST_RX_OP    = 3'd1,
    ST_RX_B     = 3'd2,
    ST_CALC     = 3'd3,
    ST_TX_START = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

  // Number of UART words needed to carry a field of the given width.
  function automatic int num_bytes(input int width, input int word_w);
    return (width + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_if.sv
// Bundle of the UART receive/transmit handshakes and the ALU operand/result bus.
//
// Handshake semantics (no ready back-pressure exists on this link):
//   rx:  i_rx_done is a one-cycle valid pulse; i_data_rx is only meaningful in
//        that cycle. The controller drops pulses it is not in a state to take.
//   tx:  o_tx_start is a one-cycle request; o_data_tx stays stable until the
//        transmitter answers with a one-cycle i_tx_done. Only one byte is ever
//        outstanding.
interface uart_alu_frame_ctrl_if
  import uart_alu_pkg::*;
#(
  parameter int W    = DEF_WORD_W,
  parameter int OPW  = DEF_OPERAND,
  parameter int OPC  = DEF_OPCODE_W,
  parameter int RESW = DEF_RESULT
);
  logic [W-1:0]    i_data_rx;
  logic            i_rx_done;
  logic            i_tx_done;
  logic [RESW-1:0] i_resultado_alu;
  logic            o_tx_start;
  logic [W-1:0]    o_data_tx;
  logic [OPW-1:0]  o_reg_dato_A;
  logic [OPW-1:0]  o_reg_dato_B;
  logic [OPC-1:0]  o_reg_opcode;
  logic            o_busy;
  logic            o_frame_error;
  state_t          o_dbg_state;

  // Controller side.
  modport master (
    input  i_data_rx, i_rx_done, i_tx_done, i_resultado_alu,
    output o_tx_start, o_data_tx, o_reg_dato_A, o_reg_dato_B, o_reg_opcode,
           o_busy, o_frame_error, o_dbg_state
  );

  // UART/ALU environment side.
  modport slave (
    output i_data_rx, i_rx_done, i_tx_done, i_resultado_alu,
    input  o_tx_start, o_data_tx, o_reg_dato_A, o_reg_dato_B, o_reg_opcode,
           o_busy, o_frame_error, o_dbg_state
  );
endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// pulses o_expire on the TIMEOUT_CYCLES-th idle cycle. 0 disables it.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign o_expire = 1'b0;
    end else begin : g_on
      logic [CW-1:0] r_count;
      logic          w_hit;

      assign w_hit    = (r_count == CW'(TIMEOUT_CYCLES - 1));
      // A clear in the expiry cycle wins: a byte arriving just in time is not an error.
      assign o_expire = i_enable && !i_clear && w_hit;

      // Idle counter; held at zero whenever the frame is not waiting for a byte.
      always_ff @(posedge i_clock) begin
        if (i_reset || i_clear || !i_enable) begin
          r_count <= '0;
        end else if (!w_hit) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller: assembles A / opcode / B from UART bytes, commits them to
// the ALU atomically, then streams the multi-byte result back out the UART.
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int WIDTH_WORD_INTERFACE   = DEF_WORD_W,
  parameter int CANT_DATOS_ENTRADA_ALU = DEF_OPERAND,
  parameter int CANT_BITS_OPCODE_ALU   = DEF_OPCODE_W,
  parameter int CANT_DATOS_SALIDA_ALU  = DEF_RESULT,
  parameter int TIMEOUT_CYCLES         = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_alu_frame_ctrl_if.master bus
);

  localparam int W     = WIDTH_WORD_INTERFACE;
  localparam int OPW   = CANT_DATOS_ENTRADA_ALU;
  localparam int OPC   = CANT_BITS_OPCODE_ALU;
  localparam int RESW  = CANT_DATOS_SALIDA_ALU;
  localparam int NA    = num_bytes(OPW, W);
  localparam int NR    = num_bytes(RESW, W);
  localparam int NMAX  = (NA > NR) ? NA : NR;
  localparam int CNT_W = $clog2(NMAX + 1);
  localparam int SHW   = NA * W;
  localparam int TXW   = NR * W;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SHW-1:0]   r_shadow_a;
  logic [SHW-1:0]   r_shadow_b;
  logic [OPC-1:0]   r_shadow_op;
  logic [TXW-1:0]   r_tx_buf;

  logic             w_rx_accept;
  logic             w_timer_en;
  logic             w_expire;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last_operand_byte;
  logic             w_last_result_byte;
  logic [SHW-1:0]   w_a_next;
  logic [SHW-1:0]   w_b_next;
  logic [TXW-1:0]   w_res_ext;

  // Byte-acceptance, timer control and next-value assembly of the shadows.
  always_comb begin
    w_rx_accept = bus.i_rx_done &&
                  ((r_state == ST_RX_A) || (r_state == ST_RX_OP) || (r_state == ST_RX_B));
    w_timer_en  = ((r_state == ST_RX_A) && (r_cnt != '0)) ||
                  (r_state == ST_RX_OP) || (r_state == ST_RX_B);
    w_cnt_inc   = r_cnt + 1'b1;
    w_last_operand_byte = (w_cnt_inc == CNT_W'(NA));
    w_last_result_byte  = (w_cnt_inc == CNT_W'(NR));
    w_a_next = r_shadow_a;
    w_a_next[r_cnt*W +: W] = bus.i_data_rx;
    w_b_next = r_shadow_b;
    w_b_next[r_cnt*W +: W] = bus.i_data_rx;
    w_res_ext = TXW'(bus.i_resultado_alu);
  end

  frame_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (w_timer_en),
    .i_clear  (w_rx_accept),
    .o_expire (w_expire)
  );

  assign bus.o_dbg_state = r_state;

  // Frame FSM with registered outputs; tx_start/data are set on the edge that
  // enters TX_START so the request is high exactly while in TX_START.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state           <= ST_RX_A;
      r_cnt             <= '0;
      r_shadow_a        <= '0;
      r_shadow_b        <= '0;
      r_shadow_op       <= '0;
      r_tx_buf          <= '0;
      bus.o_tx_start    <= 1'b0;
      bus.o_data_tx     <= '0;
      bus.o_reg_dato_A  <= '0;
      bus.o_reg_dato_B  <= '0;
      bus.o_reg_opcode  <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_frame_error <= 1'b0;
    end else begin
      bus.o_tx_start    <= 1'b0;
      bus.o_frame_error <= 1'b0;
      case (r_state)
        ST_RX_A: begin
          if (w_rx_accept) begin
            r_shadow_a <= w_a_next;
            bus.o_busy <= 1'b1;
            if (w_last_operand_byte) begin
              r_cnt   <= '0;
              r_state <= ST_RX_OP;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (w_expire) begin
            bus.o_frame_error <= 1'b1;
            bus.o_busy        <= 1'b0;
            r_shadow_a        <= '0;
            r_shadow_b        <= '0;
            r_shadow_op       <= '0;
            r_cnt             <= '0;
            r_state           <= ST_RX_A;
          end
        end

        ST_RX_OP: begin
          if (w_rx_accept) begin
            r_shadow_op <= bus.i_data_rx[OPC-1:0];
            r_cnt       <= '0;
            r_state     <= ST_RX_B;
          end else if (w_expire) begin
            bus.o_frame_error <= 1'b1;
            bus.o_busy        <= 1'b0;
            r_shadow_a        <= '0;
            r_shadow_b        <= '0;
            r_shadow_op       <= '0;
            r_cnt             <= '0;
            r_state           <= ST_RX_A;
          end
        end

        ST_RX_B: begin
          if (w_rx_accept) begin
            r_shadow_b <= w_b_next;
            if (w_last_operand_byte) begin
              // All three ALU inputs change on this one edge.
              bus.o_reg_dato_A <= r_shadow_a[OPW-1:0];
              bus.o_reg_opcode <= r_shadow_op;
              bus.o_reg_dato_B <= w_b_next[OPW-1:0];
              r_cnt            <= '0;
              r_state          <= ST_CALC;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (w_expire) begin
            bus.o_frame_error <= 1'b1;
            bus.o_busy        <= 1'b0;
            r_shadow_a        <= '0;
            r_shadow_b        <= '0;
            r_shadow_op       <= '0;
            r_cnt             <= '0;
            r_state           <= ST_RX_A;
          end
        end

        ST_CALC: begin
          r_tx_buf       <= w_res_ext;
          bus.o_data_tx  <= w_res_ext[W-1:0];
          bus.o_tx_start <= 1'b1;
          r_cnt          <= '0;
          r_state        <= ST_TX_START;
        end

        ST_TX_START: begin
          r_state <= ST_TX_WAIT;
        end

        ST_TX_WAIT: begin
          if (bus.i_tx_done) begin
            if (w_last_result_byte) begin
              r_cnt      <= '0;
              bus.o_busy <= 1'b0;
              r_state    <= ST_RX_A;
            end else begin
              r_cnt          <= w_cnt_inc;
              bus.o_data_tx  <= r_tx_buf[w_cnt_inc*W +: W];
              bus.o_tx_start <= 1'b1;
              r_state        <= ST_TX_START;
            end
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_RX_A;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
Parametrised successor of the UART↔ALU interface controller. It receives multi-byte frames from the UART receiver in this order: operand A, then opcode, then operand B. It drives the ALU inputs and returns the multi-byte ALU result through the UART transmitter, one byte per tx handshake. Unlike the single-byte controller, it adds:
- configurable operand and result widths;
- atomic commit of the ALU inputs;
- an inter-byte receive timeout with frame abort;
- busy and error status outputs.

Parameters:
WIDTH_WORD_INTERFACE, 8, UART word width W.
CANT_DATOS_ENTRADA_ALU, 16, width of operands A and B; NA = ceil(CANT_DATOS_ENTRADA_ALU/W) bytes each.
CANT_BITS_OPCODE_ALU, 8, opcode width (≤ W); the opcode is always exactly 1 byte.
CANT_DATOS_SALIDA_ALU, 16, ALU result width; NR = ceil(CANT_DATOS_SALIDA_ALU/W) bytes.
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_data_rx  in  W  received byte, valid while i_rx_done=1
i_rx_done  in  1  one-cycle pulse per received byte
i_tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
i_resultado_alu  in  CANT_DATOS_SALIDA_ALU  combinational ALU result
o_tx_start  out  1  one-cycle pulse requesting transmission of o_data_tx
o_data_tx  out  W  byte to transmit, held stable until the matching i_tx_done
o_reg_dato_A  out  CANT_DATOS_ENTRADA_ALU  ALU operand A
o_reg_dato_B  out  CANT_DATOS_ENTRADA_ALU  ALU operand B
o_reg_opcode  out  CANT_BITS_OPCODE_ALU  ALU opcode
o_busy  out  1  high from the first byte of a frame until the last result byte's i_tx_done
o_frame_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All registers update on the rising edge of i_clock.
- Reset (i_reset=1 at an edge): state RX_A, byte counter 0, timer 0, shadow registers 0. All outputs go to 0. Reset mid-frame or mid-transmission discards everything; no further o_tx_start is issued.
- States: RX_A, RX_OP, RX_B, CALC, TX_START, TX_WAIT.
- RX_A: each i_rx_done stores i_data_rx into shadow A byte[cnt] (little-endian: first byte goes to bits [W-1:0]); cnt++. When cnt reaches NA: cnt←0, go to RX_OP. Bits beyond the operand width in the last byte are dropped.
- RX_OP: on i_rx_done, shadow opcode ← i_data_rx[CANT_BITS_OPCODE_ALU-1:0]; go to RX_B.
- RX_B: bytes are assembled as in RX_A. At the edge that receives the NA-th byte, o_reg_dato_A, o_reg_opcode and o_reg_dato_B are committed together from the shadows; go to CALC. The ALU outputs never change mid-frame.
- CALC: one settling cycle. At the next edge, latch i_resultado_alu into the tx buffer; k←0; go to TX_START.
- TX_START: o_data_tx ← buffer byte k (little-endian); o_tx_start=1 for exactly one cycle; go to TX_WAIT.
- TX_WAIT: on i_tx_done, k++. If k<NR go to TX_START, otherwise go to RX_A and drop o_busy.
- Latency: o_tx_start is high in the 2nd cycle after the cycle in which the final B byte's i_rx_done is high.
- Pulses ignored:
  - i_rx_done in CALC, TX_START or TX_WAIT is discarded; it does not start a new frame.
  - i_tx_done outside TX_WAIT is ignored.
- Timeout:
  - The timer runs while in RX_OP or RX_B, or in RX_A with cnt>0. It clears on every accepted i_rx_done.
  - When the timer reaches TIMEOUT_CYCLES: pulse o_frame_error, discard the shadows, cnt←0, go to RX_A. Committed outputs keep their previous values.
  - If i_rx_done arrives in the same cycle the timer expires, i_rx_done wins and there is no error.
  - With TIMEOUT_CYCLES=0 the timer never fires.
- o_busy: registered. It is 1 from the edge accepting the first A byte until the return to RX_A.

Decomposition:
- Shared package uart_alu_pkg holds:
  - the state enum / localparams;
  - the byte-count function ceil(width/W);
  - default width constants shared with the ALU and UART tops.
- One natural sub-module: frame_timeout_timer (inputs: enable, clear; output: expire pulse; parameter TIMEOUT_CYCLES; counter width = clog2(TIMEOUT_CYCLES+1)).

Test Plan:
Bench configuration unless noted: W=8, operands 16, result 16, TIMEOUT_CYCLES=50. The ALU model is op 0x20 = add.
1. Basic frame: rx 0x34,0x12,0x20,0x01,0x00 → A=0x1234, op=0x20, B=0x0001 committed together; o_tx_start 2 cycles after the last rx_done; tx bytes 0x35 then 0x12, each after the prior i_tx_done; o_busy falls on the 2nd i_tx_done.
2. Atomic commit: previous frame A=0x1234. Send new A bytes 0xFF,0xFF and opcode only → o_reg_dato_A stays 0x1234 until the final B byte.
3. Timeout: rx 0x34, then 50 idle cycles → single o_frame_error pulse, return to RX_A. The next full frame 0x01,0x00,0x20,0x02,0x00 yields tx 0x03,0x00.
4. Race: i_rx_done in the exact cycle the timer would expire → no error, byte accepted.
5. Ignored pulses: i_rx_done pulses during TX_WAIT and stray i_tx_done in RX_A → no state change; the next frame decodes correctly.
6. Reset mid-transmission: assert i_reset after the first tx byte → all outputs 0 and no further o_tx_start. Repeat test 1 with CANT_DATOS_ENTRADA_ALU=12 / CANT_DATOS_SALIDA_ALU=8: upper nibble of the 2nd byte dropped; one tx byte.
